pe_feeder: RTL

Upstream load sequencer for a single `pe`. It accepts a host word stream over a valid/ready handshake and forwards the leading instruction words to the PE instruction port. It stages the following data words in an internal buffer and replays them to the PE data port as one gap-free burst, because the PE's data-memory load counter clears whenever `din_pe_v` drops. It then counts PE result pulses and drives `alpha_v` during the final iteration.

---
 rtl/pe_feeder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: host word sequencer for one PE. Forwards instructions, buffers data,
// replays the data as one gap-free burst, then counts results and flags the final
// iteration with alpha_v.
module pe_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned INST_NUM   = 8,
  parameter int unsigned DATA_NUM   = 16,
  parameter int unsigned RES_NUM    = 4,
  parameter int unsigned ITER_NUM   = 4,
  localparam int unsigned S_WIDTH   = (INST_WIDTH > DATA_WIDTH * 2) ? INST_WIDTH : DATA_WIDTH * 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [S_WIDTH-1:0]      s_data,
  output logic                    inst_in_v,
  output logic [INST_WIDTH-1:0]   inst_in,
  output logic                    din_pe_v,
  output logic [DATA_WIDTH*2-1:0] din_pe,
  input  logic                    res_v,
  output logic                    alpha_v,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW2  = DATA_WIDTH * 2;
  localparam int unsigned ICW  = $clog2(INST_NUM + 1);
  localparam int unsigned DCW  = $clog2(DATA_NUM + 1);
  localparam int unsigned RCW  = $clog2(RES_NUM * ITER_NUM + 1);
  localparam int unsigned AW   = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int unsigned RCW1 = RCW + 1;

  localparam logic [ICW-1:0]  INST_LAST = ICW'(INST_NUM);
  localparam logic [DCW-1:0]  DATA_LAST = DCW'(DATA_NUM);
  localparam logic [RCW-1:0]  RES_LAST  = RCW'(RES_NUM * ITER_NUM);
  // Final-iteration threshold plus one, so the compare never degenerates to ">= 0".
  localparam logic [RCW1-1:0] ALPHA_TH1 = RCW1'(RES_NUM * (ITER_NUM - 1) + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_INST = 3'd1,
    LD_DATA = 3'd2,
    BURST   = 3'd3,
    RUN     = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ICW-1:0]          inst_cnt_q, inst_cnt_d;
  logic [DCW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [DCW-1:0]          rd_cnt_q, rd_cnt_d;
  logic [RCW-1:0]          res_cnt_q, res_cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic                    inst_in_v_q, inst_in_v_d;
  logic [INST_WIDTH-1:0]   inst_in_q, inst_in_d;
  logic                    din_pe_v_q, din_pe_v_d;
  logic [DW2-1:0]          din_pe_q, din_pe_d;
  logic                    alpha_v_q, alpha_v_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DW2-1:0]          buf_q [DATA_NUM];
  logic                    buf_we;
  logic [AW-1:0]           wr_idx;
  logic [AW-1:0]           rd_idx;
  logic                    hs;

  assign hs     = s_valid && s_ready_q;
  assign wr_idx = wr_cnt_q[AW-1:0];
  assign rd_idx = rd_cnt_q[AW-1:0];

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    inst_cnt_d  = inst_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    res_cnt_d   = res_cnt_q;
    inst_in_v_d = 1'b0;
    inst_in_d   = inst_in_q;
    din_pe_v_d  = 1'b0;
    din_pe_d    = din_pe_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          inst_in_v_d = 1'b1;
          inst_in_d   = s_data[INST_WIDTH-1:0];
          inst_cnt_d  = ICW'(1);
          state_d     = (INST_NUM == 1) ? LD_DATA : LD_INST;
        end
      end
      LD_INST: begin
        if (hs) begin
          inst_in_v_d = 1'b1;
          inst_in_d   = s_data[INST_WIDTH-1:0];
          inst_cnt_d  = inst_cnt_q + ICW'(1);
          if (inst_cnt_d == INST_LAST) state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (hs) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + DCW'(1);
          if (wr_cnt_d == DATA_LAST) begin
            // Launch word 0 on the BURST entry edge; with a one-word buffer it is
            // still being written, so take it straight from the host bus.
            state_d    = BURST;
            din_pe_v_d = 1'b1;
            din_pe_d   = (DATA_NUM == 1) ? s_data[DW2-1:0] : buf_q[0];
            rd_cnt_d   = DCW'(1);
          end
        end
      end
      BURST: begin
        if (rd_cnt_q == DATA_LAST) begin
          state_d = RUN;
        end else begin
          din_pe_v_d = 1'b1;
          din_pe_d   = buf_q[rd_idx];
          rd_cnt_d   = rd_cnt_q + DCW'(1);
        end
      end
      RUN: begin
        if (res_v) begin
          res_cnt_d = res_cnt_q + RCW'(1);
          if (res_cnt_d == RES_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      inst_cnt_d = '0;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      res_cnt_d  = '0;
    end

    s_ready_d = (state_d == IDLE) || (state_d == LD_INST) || (state_d == LD_DATA);
    busy_d    = (state_d != IDLE);
    alpha_v_d = (state_d == RUN) && ((RCW1'(res_cnt_d) + RCW1'(1)) >= ALPHA_TH1);
  end

  // State, counters and outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      inst_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      res_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      inst_in_v_q <= 1'b0;
      inst_in_q   <= '0;
      din_pe_v_q  <= 1'b0;
      din_pe_q    <= '0;
      alpha_v_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_cnt_q  <= inst_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      res_cnt_q   <= res_cnt_d;
      s_ready_q   <= s_ready_d;
      inst_in_v_q <= inst_in_v_d;
      inst_in_q   <= inst_in_d;
      din_pe_v_q  <= din_pe_v_d;
      din_pe_q    <= din_pe_d;
      alpha_v_q   <= alpha_v_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Data staging buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx] <= s_data[DW2-1:0];
  end

  assign s_ready   = s_ready_q;
  assign inst_in_v = inst_in_v_q;
  assign inst_in   = inst_in_q;
  assign din_pe_v  = din_pe_v_q;
  assign din_pe    = din_pe_q;
  assign alpha_v   = alpha_v_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
